// File: rtl/pixel_write_queue.sv
// pixel_write_queue: FIFO between the drawing datapath and the frame-buffer
// write port. Each pixel is turned into a linear address (y*SCREEN_W + x) and
// queued. The head is written out through registered wr_en/wr_addr/wr_data
// whenever the frame buffer is not busy.
// Optional feature macro: PIXEL_CLIP_EN. When it is defined, off-screen pixels
// are counted and discarded, and the clip_count output is added.
module pixel_write_queue #(
    parameter int DEPTH    = 8,
    parameter int SCREEN_W = 160,
    parameter int SCREEN_H = 120,
    parameter int ADDR_W   = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        x,
    input  logic [6:0]        y,
    input  logic [2:0]        color,
    input  logic              plot,
    input  logic              frame_end,
    output logic              ready,
    input  logic              mem_busy,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [2:0]        wr_data,
    output logic              frame_done,
    output logic              overflow
`ifdef PIXEL_CLIP_EN
    ,
    output logic [7:0]        clip_count
`endif
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int EW = ADDR_W + 4;

    // The address space must be able to hold a whole screen.
    if (SCREEN_W * SCREEN_H > (2 ** ADDR_W)) begin : g_addr_check
        $error("ADDR_W too small for SCREEN_W*SCREEN_H");
    end

    typedef enum logic [1:0] {IDLE, DRAIN, STALL} state_t;

    state_t            state, state_next;
    logic [EW-1:0]     mem [DEPTH];
    logic [PW-1:0]     rd_ptr, wr_ptr;
    logic [CW-1:0]     count, count_next;
    logic [ADDR_W-1:0] pix_addr;
    logic              full, push, pop, accepted, overflow_set, done_set;
    logic              out_of_range, out_last;
    logic [EW-1:0]     head;
`ifdef PIXEL_CLIP_EN
    logic              clip_end, end_pending;
`endif

    // Address formation, range check, and push/pop decisions.
    always_comb begin
        pix_addr = ADDR_W'(y) * ADDR_W'(SCREEN_W) + ADDR_W'(x);
`ifdef PIXEL_CLIP_EN
        out_of_range = (32'(x) >= SCREEN_W) || (32'(y) >= SCREEN_H);
`else
        out_of_range = 1'b0;
`endif
        full         = (count == CW'(DEPTH));
        ready        = !full;
        push         = plot && !full && !out_of_range;
        overflow_set = plot && full && !out_of_range;
        accepted     = push || (plot && out_of_range);
        pop          = (state != IDLE) && !mem_busy;
        head         = mem[rd_ptr];
        count_next   = count;
        if (push && !pop) begin
            count_next = count + CW'(1);
        end else if (pop && !push) begin
            count_next = count - CW'(1);
        end
`ifdef PIXEL_CLIP_EN
        clip_end = plot && out_of_range && frame_end;
        done_set = (wr_en && out_last) || (clip_end && count == '0) ||
                   (end_pending && count == '0);
`else
        done_set = wr_en && out_last;
`endif
    end

    // Next control state follows the occupancy the queue will have next cycle.
    always_comb begin
        state_next = IDLE;
        if (count_next != '0) begin
            state_next = mem_busy ? STALL : DRAIN;
        end
    end

    // Queue storage; an entry is {frame_end, color, address}.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {frame_end, color, pix_addr};
        end
    end

    // Pointers, occupancy, state, the write port, and sticky status flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            out_last   <= 1'b0;
            frame_done <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            state <= state_next;
            count <= count_next;
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr   <= rd_ptr + PW'(1);
                wr_en    <= 1'b1;
                wr_addr  <= head[ADDR_W-1:0];
                wr_data  <= head[ADDR_W+2:ADDR_W];
                out_last <= head[EW-1];
            end else begin
                wr_en    <= 1'b0;
                out_last <= 1'b0;
            end
            if (done_set) begin
                frame_done <= 1'b1;
            end else if (accepted) begin
                frame_done <= 1'b0;
            end
            if (overflow_set) begin
                overflow <= 1'b1;
            end
        end
    end

`ifdef PIXEL_CLIP_EN
    // Clipped-pixel counter, plus a deferred frame end for a clipped last pixel.
    always_ff @(posedge clk) begin
        if (reset) begin
            clip_count  <= '0;
            end_pending <= 1'b0;
        end else begin
            if (plot && out_of_range && clip_count != 8'hFF) begin
                clip_count <= clip_count + 8'd1;
            end
            if (clip_end && count != '0) begin
                end_pending <= 1'b1;
            end else if (count == '0) begin
                end_pending <= 1'b0;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pixel_write_queue.sv
// tb_pixel_write_queue: directed tests for pixel_write_queue. Each scenario
// task drives its own stimulus and checks results against hand-computed values.
module tb_pixel_write_queue;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  x;
    logic [6:0]  y;
    logic [2:0]  color;
    logic        plot;
    logic        frame_end;
    logic        ready;
    logic        mem_busy;
    logic        wr_en;
    logic [14:0] wr_addr;
    logic [2:0]  wr_data;
    logic        frame_done;
    logic        overflow;
`ifdef PIXEL_CLIP_EN
    logic [7:0]  clip_count;
`endif

    int tests = 0;
    int fails = 0;
    logic [17:0] seen [$];

    pixel_write_queue dut (
        .clk        (clk),
        .reset      (reset),
        .x          (x),
        .y          (y),
        .color      (color),
        .plot       (plot),
        .frame_end  (frame_end),
        .ready      (ready),
        .mem_busy   (mem_busy),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .frame_done (frame_done),
        .overflow   (overflow)
`ifdef PIXEL_CLIP_EN
        ,
        .clip_count (clip_count)
`endif
    );

    always #5 clk = ~clk;

    // Record every write seen on the frame-buffer port as {data, addr}.
    always @(negedge clk) begin
        if (wr_en === 1'b1) seen.push_back({wr_data, wr_addr});
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; plot = 1'b0; frame_end = 1'b0; mem_busy = 1'b0;
        x = '0; y = '0; color = '0;
        step();
        step();
        tests++; if (wr_en !== 1'b0) begin fails++; $display("[TB] FAIL reset_wr_en got %b want 0", wr_en); end
        tests++; if (wr_addr !== 15'd0) begin fails++; $display("[TB] FAIL reset_wr_addr got %0d want 0", wr_addr); end
        tests++; if (wr_data !== 3'd0) begin fails++; $display("[TB] FAIL reset_wr_data got %0d want 0", wr_data); end
        tests++; if (ready !== 1'b1) begin fails++; $display("[TB] FAIL reset_ready got %b want 1", ready); end
        tests++; if (frame_done !== 1'b0 || overflow !== 1'b0) begin
            fails++; $display("[TB] FAIL reset_flags got done=%b ovf=%b want 0 0", frame_done, overflow);
        end
        reset = 1'b0;
    endtask

    task automatic test_single_pixel();
        seen.delete();
        x = 8'd5; y = 7'd2; color = 3'b101; plot = 1'b1;
        step();
        plot = 1'b0;
        tests++; if (wr_en !== 1'b0) begin fails++; $display("[TB] FAIL single_early got %b want 0", wr_en); end
        step();
        tests++; if (wr_en !== 1'b1) begin fails++; $display("[TB] FAIL single_wr_en got %b want 1", wr_en); end
        tests++; if (wr_addr !== 15'd325) begin fails++; $display("[TB] FAIL single_addr got %0d want 325", wr_addr); end
        tests++; if (wr_data !== 3'd5) begin fails++; $display("[TB] FAIL single_data got %0d want 5", wr_data); end
        step();
        tests++; if (wr_en !== 1'b0) begin fails++; $display("[TB] FAIL single_pulse got %b want 0", wr_en); end
        step();
        tests++; if (seen.size() != 1) begin fails++; $display("[TB] FAIL single_count got %0d want 1", seen.size()); end
    endtask

    task automatic test_corner_frame_end();
        x = 8'd159; y = 7'd119; color = 3'd2; frame_end = 1'b1; plot = 1'b1;
        step();
        plot = 1'b0; frame_end = 1'b0;
        step();
        tests++; if (wr_en !== 1'b1 || wr_addr !== 15'd19199) begin
            fails++; $display("[TB] FAIL corner_write got en=%b addr=%0d want 1 19199", wr_en, wr_addr);
        end
        tests++; if (frame_done !== 1'b0) begin fails++; $display("[TB] FAIL corner_done_early got %b want 0", frame_done); end
        step();
        tests++; if (frame_done !== 1'b1) begin fails++; $display("[TB] FAIL corner_done got %b want 1", frame_done); end
        step();
        tests++; if (frame_done !== 1'b1) begin fails++; $display("[TB] FAIL corner_done_sticky got %b want 1", frame_done); end
        x = 8'd0; y = 7'd0; plot = 1'b1;
        step();
        plot = 1'b0;
        tests++; if (frame_done !== 1'b0) begin fails++; $display("[TB] FAIL corner_done_clear got %b want 0", frame_done); end
        step();
        step();
    endtask

    task automatic test_backpressure();
        mem_busy = 1'b1;
        for (int i = 0; i < 8; i++) begin
            x = 8'(i * 10); y = 7'(i + 1); color = 3'(i); plot = 1'b1;
            step();
            tests++; if (ready !== (i < 7)) begin
                fails++; $display("[TB] FAIL bp_ready_%0d got %b want %b", i, ready, (i < 7));
            end
        end
        x = 8'd99; y = 7'd99; color = 3'd7; plot = 1'b1;
        step();
        plot = 1'b0;
        tests++; if (overflow !== 1'b1) begin fails++; $display("[TB] FAIL bp_overflow got %b want 1", overflow); end
        tests++; if (wr_en !== 1'b0) begin fails++; $display("[TB] FAIL bp_busy_write got %b want 0", wr_en); end
        mem_busy = 1'b0;
        for (int k = 0; k < 8; k++) begin
            step();
            tests++; if (wr_en !== 1'b1 || wr_addr !== 15'((k + 1) * 160 + k * 10) || wr_data !== 3'(k)) begin
                fails++; $display("[TB] FAIL bp_drain_%0d got en=%b addr=%0d data=%0d want 1 %0d %0d",
                                  k, wr_en, wr_addr, wr_data, (k + 1) * 160 + k * 10, k);
            end
        end
        step();
        tests++; if (wr_en !== 1'b0) begin fails++; $display("[TB] FAIL bp_drain_end got %b want 0", wr_en); end
        tests++; if (overflow !== 1'b1) begin fails++; $display("[TB] FAIL bp_overflow_sticky got %b want 1", overflow); end
    endtask

    task automatic test_reset_midflight();
        mem_busy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            x = 8'(i); y = 7'(i); color = 3'(i); plot = 1'b1;
            step();
        end
        plot = 1'b0; reset = 1'b1; mem_busy = 1'b0;
        step();
        reset = 1'b0;
        seen.delete();
        tests++; if (ready !== 1'b1 || overflow !== 1'b0 || frame_done !== 1'b0) begin
            fails++; $display("[TB] FAIL midreset_flags got rdy=%b ovf=%b done=%b want 1 0 0", ready, overflow, frame_done);
        end
        tests++; if (wr_en !== 1'b0) begin fails++; $display("[TB] FAIL midreset_wr_en got %b want 0", wr_en); end
        repeat (6) step();
        tests++; if (seen.size() != 0) begin fails++; $display("[TB] FAIL midreset_writes got %0d want 0", seen.size()); end
    endtask

    task automatic test_back_to_back();
        logic [17:0] expq [$];
        int n;
        reset = 1'b1;
        step();
        reset = 1'b0;
        seen.delete();
        n = 0;
        for (int c = 0; c < 60; c++) begin
            mem_busy = (c % 2 == 1);
            if (n < 20 && ready === 1'b1) begin
                x = 8'((n * 13) % 160); y = 7'((n * 7) % 120); color = 3'(n % 8); plot = 1'b1;
                expq.push_back({3'(n % 8), 15'(((n * 7) % 120) * 160 + (n * 13) % 160)});
                n++;
            end else begin
                plot = 1'b0;
            end
            step();
        end
        plot = 1'b0; mem_busy = 1'b0;
        repeat (12) step();
        tests++; if (seen.size() != 20) begin fails++; $display("[TB] FAIL b2b_count got %0d want 20", seen.size()); end
        for (int i = 0; i < 20; i++) begin
            if (i < seen.size() && i < expq.size()) begin
                tests++; if (seen[i] !== expq[i]) begin
                    fails++; $display("[TB] FAIL b2b_entry_%0d got %h want %h", i, seen[i], expq[i]);
                end
            end
        end
        tests++; if (overflow !== 1'b0) begin fails++; $display("[TB] FAIL b2b_overflow got %b want 0", overflow); end
    endtask

`ifdef PIXEL_CLIP_EN
    task automatic test_clip();
        seen.delete();
        x = 8'd200; y = 7'd10; color = 3'd1; plot = 1'b1;
        step();
        plot = 1'b0;
        repeat (3) step();
        tests++; if (seen.size() != 0) begin fails++; $display("[TB] FAIL clip_write got %0d want 0", seen.size()); end
        tests++; if (clip_count !== 8'd1) begin fails++; $display("[TB] FAIL clip_count got %0d want 1", clip_count); end
        tests++; if (overflow !== 1'b0) begin fails++; $display("[TB] FAIL clip_overflow got %b want 0", overflow); end
    endtask
`endif

    initial begin
        test_reset();
        test_single_pixel();
        test_corner_frame_end();
        test_backpressure();
        test_reset_midflight();
        test_back_to_back();
`ifdef PIXEL_CLIP_EN
        test_clip();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pixel_write_queue.md
Name: pixel_write_queue

Overview:
- Buffers pixels between the full-screen drawing datapath (x, y, colour, plot, frame-end flag) and the frame-buffer write port.
- Converts each (x, y) pixel to a linear address, addr = y*160 + x, and issues registered writes.
- Applies back-pressure upstream while the frame buffer is busy.
- Reports when the final pixel of a frame has actually been written.

Parameters:
- DEPTH, 8, FIFO entries; power of two, 2..64.
- SCREEN_W, 160, pixels per line; used in the address multiply.
- SCREEN_H, 120, lines per frame; used only by the optional clip feature.
- ADDR_W, 15, width of wr_addr; must satisfy 2^ADDR_W >= SCREEN_W*SCREEN_H.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- x  in  8  pixel column from the drawing datapath.
- y  in  7  pixel row.
- color  in  3  pixel colour.
- plot  in  1  pixel valid strobe; one pixel per cycle.
- frame_end  in  1  marks this pixel as the last of the frame; sampled only with plot.
- ready  out  1  queue can accept a pixel this cycle; equals !full.
- mem_busy  in  1  frame buffer cannot take a write this cycle.
- wr_en  out  1  write strobe to the frame buffer.
- wr_addr  out  ADDR_W  linear pixel address.
- wr_data  out  3  pixel colour.
- frame_done  out  1  sticky: the tagged last pixel has been written.
- overflow  out  1  sticky: a plot arrived while the queue was full.

Behaviour:
- Reset (synchronous, active-high):
  - count=0, rd_ptr=wr_ptr=0.
  - wr_en=0, wr_addr=0, wr_data=0.
  - frame_done=0, overflow=0, ready=1.
  - Reset mid-operation discards all queued pixels; no wr_en in the cycle after reset.
- Push:
  - Occurs when plot && !full.
  - Entry stored = {frame_end, color, addr}.
  - addr = (y<<7) + (y<<5) + x, computed combinationally before storage, zero-extended to ADDR_W.
- Push while full:
  - The pixel is dropped and overflow is set; overflow stays set until reset.
  - A pop in the same cycle does not rescue the push. full is evaluated on the pre-edge count.
- Pop:
  - Occurs when count>0 && !mem_busy.
  - The head entry loads into the output registers; wr_en=1 for exactly that following cycle.
  - Otherwise wr_en=0. wr_addr and wr_data hold their last values.
- Latency: a pixel pushed at edge N, with an empty queue and mem_busy=0, appears with wr_en=1 in the cycle after edge N+1.
- Throughput: one write per cycle while mem_busy=0 and count>0.
- Simultaneous push and pop (not full): count is unchanged; both pointers advance.
- Pointers wrap modulo DEPTH; count ranges 0..DEPTH.
- full = (count==DEPTH); ready = !full, combinational from registered count.
- frame_done:
  - Set on the edge after a wr_en cycle whose entry carried frame_end=1.
  - Cleared on the next accepted push; reset clears it.
  - A push and the set in the same cycle: the set wins.
- mem_busy asserted with count=0 has no effect. mem_busy never drops an entry.
- Control state machine:
  - States: IDLE (count=0), DRAIN (count>0, !mem_busy), STALL (count>0, mem_busy).
  - The state machine is informational only; output timing is defined by the rules above.

Optional Feature:
- Macro: PIXEL_CLIP_EN.
- Defined:
  - A plot with x>=SCREEN_W or y>=SCREEN_H is accepted but not stored. It does not set overflow.
  - It still honours frame_end: frame_done sets on the next edge if the queue is empty, otherwise with the last queued write.
  - Extra output clip_count [7:0] counts clipped pixels, saturating at 255; reset clears it.
- Undefined:
  - No range check is made; out-of-range addresses are written as computed.
  - clip_count is absent.

Test Plan:
- Reset then a single pixel: x=5, y=2, color=3'b101, mem_busy=0 -> exactly one wr_en pulse with wr_addr=325, wr_data=5, two cycles after the plot cycle.
- Corner pixel x=159, y=119, frame_end=1 -> wr_addr=19199; frame_done=1 the cycle after that write; the next plot clears it.
- mem_busy=1 with 8 plots, then a 9th plot -> ready=0 after the 8th; the 9th sets overflow; release mem_busy -> 8 consecutive writes in push order, addresses correct.
- Continuous plot with mem_busy toggling every cycle -> no loss, no duplication, in-order addresses; count never exceeds DEPTH.
- Reset asserted with 4 entries queued -> no further wr_en; ready=1, overflow=0, frame_done=0.
- PIXEL_CLIP_EN: plot x=200, y=10 -> no write; clip_count=1; overflow stays 0.
